// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Sequencer for the multi-cycle multiply/divide datapath. It owns the
//   architectural HI/LO registers and accepts one operation at a time from
//   the control unit. MULT/DIV launch the iterative units through a
//   start/done handshake, and the control unit is stalled while a unit is
//   running. MFHI/MFLO/MTHI/MTLO each complete in a single cycle.
//
//   Optional feature: define MULDIV_TIMEOUT_EN to add a wait watchdog. If a
//   unit does not report done within TIMEOUT wait cycles, the operation is
//   aborted (timeout + unit_abort pulses) and HI/LO are left unchanged.
//   Without the macro, a wait lasts until done, and timeout/unit_abort are
//   tied low.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   op_valid, op_code           request; accepted when op_valid && op_ready
//   op_a, op_b                  operands (op_a is also the MTHI/MTLO data)
//   op_ready, busy              ready only in IDLE; busy is its complement
//   mult_start, div_start       one-cycle unit launch pulses
//   unit_a, unit_b              operands to both units, stable while busy
//   mult_done, div_done         unit completion pulses
//   mult_hi/lo, div_hi/lo       unit results (div_hi = remainder)
//   hi, lo                      architectural HI/LO
//   rd_data, rd_valid           MFHI/MFLO result and its one-cycle strobe
//   result_valid                one-cycle pulse when MULT/DIV updates HI/LO
//   div_zero                    one-cycle pulse for a DIV by zero (no launch)
//   unit_abort, timeout         one-cycle watchdog pulses
//
// States
//   IDLE       | ready for a new operation
//   MULT_START | mult_start asserted for this cycle
//   MULT_WAIT  | waiting for mult_done
//   DIV_START  | div_start asserted for this cycle
//   DIV_WAIT   | waiting for div_done

module muldiv_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  output logic        busy,
  output logic        mult_start,
  output logic        div_start,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        mult_done,
  input  logic        div_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        result_valid,
  output logic        div_zero,
  output logic        unit_abort,
  output logic        timeout
);

  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MFHI = 3'b011;
  localparam logic [2:0] OP_MFLO = 3'b100;
  localparam logic [2:0] OP_MTHI = 3'b101;
  localparam logic [2:0] OP_MTLO = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    MULT_START,
    MULT_WAIT,
    DIV_START,
    DIV_WAIT
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   wait_hit;   // watchdog expiry in the current wait cycle
  logic   abort_now;  // expiry without a done in the same cycle

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mult_start = 1'b0;
    div_start  = 1'b0;
    op_ready   = 1'b0;
    abort_now  = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          if (op_code == OP_MULT)
            state_nxt = MULT_START;
          else if (op_code == OP_DIV && op_b != 32'd0)
            state_nxt = DIV_START;
        end
      end
      MULT_START: begin
        mult_start = 1'b1;
        state_nxt  = MULT_WAIT;
      end
      MULT_WAIT: begin
        if (mult_done) begin
          state_nxt = IDLE;
        end else if (wait_hit) begin
          abort_now = 1'b1;
          state_nxt = IDLE;
        end
      end
      DIV_START: begin
        div_start = 1'b1;
        state_nxt = DIV_WAIT;
      end
      DIV_WAIT: begin
        if (div_done) begin
          state_nxt = IDLE;
        end else if (wait_hit) begin
          abort_now = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = ~op_ready;
  assign accept = op_valid & op_ready;

  // Accepts happen only in IDLE and completions only in a WAIT state, so the
  // HI/LO writes below can never collide in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi           <= 32'd0;
      lo           <= 32'd0;
      rd_data      <= 32'd0;
      unit_a       <= 32'd0;
      unit_b       <= 32'd0;
      rd_valid     <= 1'b0;
      result_valid <= 1'b0;
      div_zero     <= 1'b0;
    end else begin
      rd_valid     <= 1'b0;
      result_valid <= 1'b0;
      div_zero     <= 1'b0;
      if (accept) begin
        case (op_code)
          OP_MULT: begin
            unit_a <= op_a;
            unit_b <= op_b;
          end
          OP_DIV: begin
            if (op_b == 32'd0) begin
              div_zero <= 1'b1;
            end else begin
              unit_a <= op_a;
              unit_b <= op_b;
            end
          end
          OP_MFHI: begin
            rd_data  <= hi;
            rd_valid <= 1'b1;
          end
          OP_MFLO: begin
            rd_data  <= lo;
            rd_valid <= 1'b1;
          end
          OP_MTHI: hi <= op_a;
          OP_MTLO: lo <= op_a;
          default: ;
        endcase
      end
      if (state == MULT_WAIT && mult_done) begin
        hi           <= mult_hi;
        lo           <= mult_lo;
        result_valid <= 1'b1;
      end
      if (state == DIV_WAIT && div_done) begin
        hi           <= div_hi;
        lo           <= div_lo;
        result_valid <= 1'b1;
      end
    end
  end

`ifdef MULDIV_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       timeout_q;

  // Cleared in the START cycle so it reads 0 in the first WAIT cycle; the
  // TIMEOUT-th wait cycle is the one where the count equals TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort_now;
      if (state == MULT_START || state == DIV_START)
        wait_cnt <= 8'd0;
      else if (state == MULT_WAIT || state == DIV_WAIT)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign wait_hit   = (wait_cnt == 8'(TIMEOUT - 1));
  assign timeout    = timeout_q;
  assign unit_abort = timeout_q;
`else
  assign wait_hit   = 1'b0;
  assign timeout    = 1'b0;
  assign unit_abort = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  localparam logic [2:0] NOP  = 3'd0, MULT = 3'd1, DIV  = 3'd2, MFHI = 3'd3,
                         MFLO = 3'd4, MTHI = 3'd5, MTLO = 3'd6, RSVD = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        op_ready, busy, mult_start, div_start;
  logic [31:0] unit_a, unit_b;
  logic        mult_done, div_done;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic [31:0] hi, lo, rd_data;
  logic        rd_valid, result_valid, div_zero, unit_abort, timeout;

  int n_vec = 0;
  int n_err = 0;

  // Architectural model: the HI/LO values the spec says must be visible.
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  muldiv_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_code(op_code), .op_a(op_a), .op_b(op_b),
    .op_ready(op_ready), .busy(busy),
    .mult_start(mult_start), .div_start(div_start),
    .unit_a(unit_a), .unit_b(unit_b),
    .mult_done(mult_done), .div_done(div_done),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .hi(hi), .lo(lo), .rd_data(rd_data), .rd_valid(rd_valid),
    .result_valid(result_valid), .div_zero(div_zero),
    .unit_abort(unit_abort), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issues one operation starting at a negedge and returns at a negedge with
  // the controller idle again. lat = extra wait cycles before done; spur
  // injects the other unit's done mid-wait; hold keeps an MFHI request
  // asserted through the whole multi-cycle operation.
  task automatic do_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] rh, input logic [31:0] rl,
                       input bit spur, input bit hold);
    bit is_mul, launch;
    is_mul = (code == MULT);
    launch = is_mul || (code == DIV && b != 32'd0);
    chk("ready_at_issue", op_ready, 1);
    chk("busy_at_issue", busy, 0);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
    @(negedge clk);
    if (launch) begin
      chk("start_pulse", is_mul ? mult_start : div_start, 1);
      chk("other_start", is_mul ? div_start : mult_start, 0);
      chk("busy_in_start", busy, 1);
      chk("unit_a", unit_a, a);
      chk("unit_b", unit_b, b);
      if (hold) begin
        op_code = MFHI; op_a = $urandom;
      end else begin
        op_valid = 1'b0;
      end
      @(negedge clk);
      chk("start_single", is_mul ? mult_start : div_start, 0);
      for (int i = 0; i < lat; i++) begin
        chk("busy_in_wait", busy, 1);
        chk("no_rd_in_wait", rd_valid, 0);
        chk("no_result_in_wait", result_valid, 0);
        if (spur && i == lat / 2) begin
          if (is_mul) div_done = 1'b1; else mult_done = 1'b1;
          mult_hi = $urandom; mult_lo = $urandom; div_hi = $urandom; div_lo = $urandom;
        end
        @(negedge clk);
        mult_done = 1'b0; div_done = 1'b0;
      end
      mult_hi = $urandom; mult_lo = $urandom; div_hi = $urandom; div_lo = $urandom;
      if (is_mul) begin
        mult_hi = rh; mult_lo = rl; mult_done = 1'b1;
      end else begin
        div_hi = rh; div_lo = rl; div_done = 1'b1;
      end
      @(negedge clk);
      mult_done = 1'b0; div_done = 1'b0;
      mult_hi = $urandom; mult_lo = $urandom; div_hi = $urandom; div_lo = $urandom;
      m_hi = rh; m_lo = rl;
      chk("result_valid", result_valid, 1);
      chk("hi_after_done", hi, m_hi);
      chk("lo_after_done", lo, m_lo);
      chk("ready_after_done", op_ready, 1);
      chk("no_rd_with_result", rd_valid, 0);
      if (hold) begin
        // MFHI still asserted: it is accepted in the result_valid cycle.
        @(negedge clk);
        op_valid = 1'b0;
        chk("held_mfhi_valid", rd_valid, 1);
        chk("held_mfhi_data", rd_data, m_hi);
        chk("result_single", result_valid, 0);
      end
    end else begin
      op_valid = 1'b0;
      case (code)
        DIV: begin
          chk("div_zero", div_zero, 1);
          chk("dz_busy", busy, 0);
          chk("dz_no_start", div_start, 0);
        end
        MFHI: begin
          chk("mfhi_valid", rd_valid, 1);
          chk("mfhi_data", rd_data, m_hi);
        end
        MFLO: begin
          chk("mflo_valid", rd_valid, 1);
          chk("mflo_data", rd_data, m_lo);
        end
        MTHI: m_hi = a;
        MTLO: m_lo = a;
        default: begin
          chk("nop_rd_valid", rd_valid, 0);
          chk("nop_div_zero", div_zero, 0);
        end
      endcase
      if (code != DIV) chk("no_div_zero", div_zero, 0);
      chk("single_cycle_ready", op_ready, 1);
      chk("hi_model", hi, m_hi);
      chk("lo_model", lo, m_lo);
      chk("no_result_valid", result_valid, 0);
      chk("no_timeout", timeout, 0);
      chk("no_abort", unit_abort, 0);
    end
  endtask

  initial begin
    logic [2:0]  code;
    logic [31:0] a, b;
    reset = 1'b1; op_valid = 1'b0; op_code = NOP; op_a = '0; op_b = '0;
    mult_done = 1'b0; div_done = 1'b0;
    mult_hi = '0; mult_lo = '0; div_hi = '0; div_lo = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_unit_a", unit_a, 0);
    chk("rst_unit_b", unit_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {rd_valid, result_valid, div_zero, mult_start, div_start,
                       timeout, unit_abort}, 0);
    reset = 1'b0;
    @(negedge clk);

    do_op(MULT, 32'd7, 32'd6, 32, 32'd0, 32'd42, 1'b0, 1'b0);
    do_op(DIV, 32'd100, 32'd7, 5, 32'd2, 32'd14, 1'b0, 1'b0);
    do_op(MFLO, 32'd0, 32'd0, 0, 32'd0, 32'd0, 1'b0, 1'b0);
    do_op(DIV, 32'd5, 32'd0, 0, 32'd0, 32'd0, 1'b0, 1'b0);
    do_op(DIV, 32'd9, 32'd4, 12, 32'd1, 32'd2, 1'b1, 1'b1);
    do_op(MULT, 32'hffff_ffff, 32'd2, 0, 32'hffff_ffff, 32'hffff_fffe, 1'b0, 1'b0);
    do_op(RSVD, 32'h1234, 32'h5678, 0, 32'd0, 32'd0, 1'b0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      code = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
      do_op(code, a, b, $urandom_range(0, 40), $urandom, $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a MULT; the late done must be ignored.
    do_op(MTHI, 32'hdead_beef, 32'd0, 0, 32'd0, 32'd0, 1'b0, 1'b0);
    do_op(MTLO, 32'hcafe_f00d, 32'd0, 0, 32'd0, 32'd0, 1'b0, 1'b0);
    op_valid = 1'b1; op_code = MULT; op_a = 32'd3; op_b = 32'd5;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_before_reset", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("reset_idle", op_ready, 1);
    mult_done = 1'b1; mult_hi = 32'h1111_1111; mult_lo = 32'h2222_2222;
    @(negedge clk);
    mult_done = 1'b0;
    chk("late_done_result", result_valid, 0);
    chk("late_done_busy", busy, 0);
    @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_no_result", result_valid, 0);

`ifdef MULDIV_TIMEOUT_EN
    do_op(MTHI, 32'h0bad_0bad, 32'd0, 0, 32'd0, 32'd0, 1'b0, 1'b0);
    op_valid = 1'b1; op_code = DIV; op_a = 32'd50; op_b = 32'd3;
    @(negedge clk);
    op_valid = 1'b0;
    chk("tmo_start", div_start, 1);
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      chk("tmo_busy", busy, 1);
      chk("tmo_early", timeout, 0);
      @(negedge clk);
    end
    chk("tmo_pulse", timeout, 1);
    chk("tmo_abort", unit_abort, 1);
    chk("tmo_ready", op_ready, 1);
    chk("tmo_no_result", result_valid, 0);
    chk("tmo_hi", hi, m_hi);
    chk("tmo_lo", lo, m_lo);
    @(negedge clk);
    chk("tmo_single", timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
